panel_input_conditioner: RTL

- Conditions the raw front-panel inputs (pushbuttons, sense/data toggle switches on GPIO) before they reach the altair machine core.
- Per input: 2-flop synchronizer and counter-based debouncer.
- Outputs: clean levels, one-cycle press/release strobes and a switch-change strobe.
- Sits between board pins and the machine's examine/deposit/step/reset and sense inputs.

---
 rtl/panel_input_conditioner.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/panel_input_conditioner.sv
// panel_input_conditioner: synchronizes and debounces front-panel buttons and
// switches, producing clean levels plus press/release/change strobes that are
// suppressed until a post-reset settle window has elapsed.
// Optional auto-repeat of selected buttons is built when PANEL_AUTO_REPEAT_EN
// is defined.
module panel_input_conditioner #(
  parameter int unsigned       N_BTN           = 7,
  parameter int unsigned       N_SW            = 8,
  parameter int unsigned       DEBOUNCE_CYCLES = 250000,
  parameter logic [N_BTN-1:0]  REPEAT_MASK     = N_BTN'(7'b0101000),
  parameter int unsigned       REPEAT_DELAY    = 12500000,
  parameter int unsigned       REPEAT_PERIOD   = 2500000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_SW-1:0]  sw_level,
  output logic             sw_changed,
  output logic             armed
);

  localparam int unsigned N_IN = N_BTN + N_SW;
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam int unsigned ST_W = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(DEBOUNCE_CYCLES + 1);

  // Buttons occupy the low bits, switches the high bits of every channel vector.
  logic [N_IN-1:0]            sync1_q, sync2_q;
  logic [N_IN-1:0]            stable_q, stable_d;
  logic [N_IN-1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [N_IN-1:0]            accept_c;
  logic [N_IN-1:0]            rise_c, fall_c;

  logic [ST_W-1:0]            settle_cnt_q, settle_cnt_d;
  logic                       armed_q, armed_d;

  logic [N_BTN-1:0]           btn_press_q, btn_press_d;
  logic [N_BTN-1:0]           btn_release_q, btn_release_d;
  logic                       sw_changed_q, sw_changed_d;

  logic [N_BTN-1:0]           rep_pulse_c;

  // Two-flop synchronizer for every raw input.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sw_raw, btn_raw};
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce: accept a new level after DEBOUNCE_CYCLES differing samples.
  always_comb begin
    accept_c = '0;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < N_IN; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_MAX) begin
        accept_c[i] = 1'b1;
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
      end
    end
    stable_d = stable_q ^ accept_c;
    rise_c   = accept_c & ~stable_q;
    fall_c   = accept_c & stable_q;
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stable_q <= '0;
      db_cnt_q <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Settle window: armed rises on the last cycle of the window and then holds.
  always_comb begin
    settle_cnt_d = settle_cnt_q;
    armed_d      = armed_q;
    if (!armed_q) begin
      if (settle_cnt_q == ST_LAST) begin
        armed_d = 1'b1;
      end else begin
        settle_cnt_d = settle_cnt_q + ST_W'(1);
      end
    end
  end

  // Settle window registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      settle_cnt_q <= '0;
      armed_q      <= 1'b0;
    end else begin
      settle_cnt_q <= settle_cnt_d;
      armed_q      <= armed_d;
    end
  end

`ifdef PANEL_AUTO_REPEAT_EN
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = (RP_MAX > 2) ? $clog2(RP_MAX) : 1;
  localparam logic [RP_W-1:0] RP_FIRST = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_NEXT  = RP_W'(REPEAT_PERIOD - 1);

  logic [N_BTN-1:0][RP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [N_BTN-1:0]           rep_phase_q, rep_phase_d;

  // Hold counters: first repeat after REPEAT_DELAY, then every REPEAT_PERIOD.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_pulse_c = '0;
    for (int b = 0; b < N_BTN; b++) begin
      if (!REPEAT_MASK[b] || rise_c[b] || fall_c[b] || !stable_q[b]) begin
        // A fresh press or any release restarts the hold from zero.
        rep_cnt_d[b]   = '0;
        rep_phase_d[b] = 1'b0;
      end else if (rep_cnt_q[b] == (rep_phase_q[b] ? RP_NEXT : RP_FIRST)) begin
        rep_pulse_c[b] = 1'b1;
        rep_cnt_d[b]   = '0;
        rep_phase_d[b] = 1'b1;
      end else begin
        rep_cnt_d[b] = rep_cnt_q[b] + RP_W'(1);
      end
    end
  end

  // Auto-repeat state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= '0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  logic unused_repeat_cfg_c;

  assign rep_pulse_c = '0;
  assign unused_repeat_cfg_c = ^{REPEAT_MASK, 32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

  // Strobe generation, all gated by the armed state of the previous cycle.
  always_comb begin
    btn_press_d   = '0;
    btn_release_d = '0;
    sw_changed_d  = 1'b0;
    if (armed_q) begin
      btn_press_d   = rise_c[N_BTN-1:0] | rep_pulse_c;
      btn_release_d = fall_c[N_BTN-1:0];
      sw_changed_d  = |accept_c[N_IN-1:N_BTN];
    end
  end

  // Strobe registers, aligned with the first cycle of the new level.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      btn_press_q   <= '0;
      btn_release_q <= '0;
      sw_changed_q  <= 1'b0;
    end else begin
      btn_press_q   <= btn_press_d;
      btn_release_q <= btn_release_d;
      sw_changed_q  <= sw_changed_d;
    end
  end

  assign btn_level   = stable_q[N_BTN-1:0];
  assign sw_level    = stable_q[N_IN-1:N_BTN];
  assign btn_press   = btn_press_q;
  assign btn_release = btn_release_q;
  assign sw_changed  = sw_changed_q;
  assign armed       = armed_q;

endmodule
